// File: rtl/btn_pkg.sv
// Shared state encoding and default 100 MHz timing constants for the button pulse path.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btnState_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for asynchronous board inputs; synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic stage1_q;
  logic stage2_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw button level into a clean level plus one-cycle press/release pulses.
// Define AUTO_REPEAT_EN to add held-button auto-repeat pulses on Pulse_out.
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic Clk_in,
  input  logic Reset_in,
  input  logic Level_in,
  output logic Pulse_out,
  output logic Release_out,
  output logic Stable_out
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
    $error("button_pulse_gen: timing parameters must all be >= 1");
  end

  btnState_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic pulse_q, pulse_d;
  logic release_q, release_d;
  logic stable_q, stable_d;
  logic syncLvl;
  logic pressEv;
  logic releaseEv;
  logic repeatFire;

  sync_2ff uSync (
    .clock_i (Clk_in),
    .reset_i (Reset_in),
    .d_i     (Level_in),
    .q_o     (syncLvl)
  );

  // The count only advances while below CNT_MAX, so it can never wrap.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pressEv   = 1'b0;
    releaseEv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (syncLvl) begin
          state_d = PRESS_WAIT;
          count_d = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!syncLvl) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == CNT_MAX) begin
          state_d = HELD;
          count_d = '0;
          pressEv = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      HELD: begin
        if (!syncLvl) begin
          state_d = RELEASE_WAIT;
          count_d = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (syncLvl) begin
          state_d = HELD;
          count_d = '0;
        end else if (count_q == CNT_MAX) begin
          state_d   = IDLE;
          count_d   = '0;
          releaseEv = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(maxU(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RW-1:0] rep_q, rep_d, repNext;
  logic firstRep_q, firstRep_d;

  // Repeat timing spans HELD and RELEASE_WAIT so a rejected release bounce keeps its phase.
  always_comb begin
    rep_d      = rep_q;
    firstRep_d = firstRep_q;
    repeatFire = 1'b0;
    repNext    = rep_q + 1'b1;
    if ((state_q == HELD || state_q == RELEASE_WAIT) && !releaseEv) begin
      if (repNext == (firstRep_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
        repeatFire = 1'b1;
        rep_d      = '0;
        firstRep_d = 1'b0;
      end else begin
        rep_d = repNext;
      end
    end else begin
      rep_d      = '0;
      firstRep_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      rep_q      <= '0;
      firstRep_q <= 1'b1;
    end else begin
      rep_q      <= rep_d;
      firstRep_q <= firstRep_d;
    end
  end
`else
  assign repeatFire = 1'b0;
`endif

  assign pulse_d   = pressEv | repeatFire;
  assign release_d = releaseEv;
  assign stable_d  = (state_d == HELD) || (state_d == RELEASE_WAIT);

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
      stable_q  <= stable_d;
    end
  end

  assign Pulse_out   = pulse_q;
  assign Release_out = release_q;
  assign Stable_out  = stable_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen; honours AUTO_REPEAT_EN when defined for the build.
module tb_button_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;

  logic clk = 1'b0;
  logic Reset_in = 1'b1;
  logic Level_in = 1'b0;
  logic Pulse_out, Release_out, Stable_out;
  logic toggleQ = 1'b0;

  int nChecks = 0;
  int nErrors = 0;
  int edgeNo = 0;

  // Reference model: accepted level flips after DEB+1 consecutive differing samples.
  logic mS1 = 1'b0, mS2 = 1'b0, mStable = 1'b0, expP = 1'b0, expR = 1'b0;
  int mRun = 0;
  int mHold = 0;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .Clk_in      (clk),
    .Reset_in    (Reset_in),
    .Level_in    (Level_in),
    .Pulse_out   (Pulse_out),
    .Release_out (Release_out),
    .Stable_out  (Stable_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream toggle logic driven by Pulse_out.
  always @(posedge clk) begin
    if (Reset_in) toggleQ <= 1'b0;
    else if (Pulse_out) toggleQ <= ~toggleQ;
  end

  task automatic step(input logic lvl, input logic rst);
    logic samp;
    Level_in = lvl;
    Reset_in = rst;
    @(posedge clk);
    edgeNo++;
    if (rst) begin
      mS1 = 0; mS2 = 0; mStable = 0; mRun = 0; mHold = 0; expP = 0; expR = 0;
    end else begin
      samp = mS2;
      mS2  = mS1;
      mS1  = lvl;
      expP = 0;
      expR = 0;
      if (samp != mStable) mRun++;
      else mRun = 0;
      if (mRun == DEB + 1) begin
        mRun    = 0;
        mHold   = 0;
        mStable = samp;
        if (samp) expP = 1;
        else expR = 1;
      end else if (mStable) begin
`ifdef AUTO_REPEAT_EN
        mHold++;
        if (mHold == RD || (mHold > RD && (mHold - RD) % RP == 0)) expP = 1;
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);
    nChecks++;
    if (Pulse_out !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_pulse got %b want 0", Pulse_out); end
    nChecks++;
    if (Release_out !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_release got %b want 0", Release_out); end
    nChecks++;
    if (Stable_out !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_stable got %b want 0", Stable_out); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_clean_press();
    int firstEdge, pulseEdge, pulses, rels;
    firstEdge = edgeNo + 1; pulseEdge = -1; pulses = 0; rels = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      nChecks++;
      if ({Pulse_out, Release_out, Stable_out} !== {expP, expR, mStable}) begin
        nErrors++;
        $display("[TB] FAIL press_cycle edge=%0d got PRS=%b%b%b want %b%b%b", edgeNo,
                 Pulse_out, Release_out, Stable_out, expP, expR, mStable);
      end
      if (Pulse_out) begin pulses++; pulseEdge = edgeNo; end
      if (Release_out) rels++;
    end
    nChecks++;
    if (pulses != 1) begin nErrors++; $display("[TB] FAIL press_count got %0d want 1", pulses); end
    nChecks++;
    if (pulseEdge - firstEdge + 1 != DEB + 3) begin
      nErrors++; $display("[TB] FAIL press_latency got %0d want %0d", pulseEdge - firstEdge + 1, DEB + 3);
    end
    nChecks++;
    if (rels != 0) begin nErrors++; $display("[TB] FAIL press_no_release got %0d want 0", rels); end
    nChecks++;
    if (Stable_out !== 1'b1) begin nErrors++; $display("[TB] FAIL press_stable got %b want 1", Stable_out); end
  endtask

  task automatic test_clean_release();
    int firstEdge, relEdge, pulses, rels;
    firstEdge = edgeNo + 1; relEdge = -1; pulses = 0; rels = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      nChecks++;
      if ({Pulse_out, Release_out, Stable_out} !== {expP, expR, mStable}) begin
        nErrors++;
        $display("[TB] FAIL release_cycle edge=%0d got PRS=%b%b%b want %b%b%b", edgeNo,
                 Pulse_out, Release_out, Stable_out, expP, expR, mStable);
      end
      if (Pulse_out) pulses++;
      if (Release_out) begin rels++; relEdge = edgeNo; end
    end
    nChecks++;
    if (rels != 1) begin nErrors++; $display("[TB] FAIL release_count got %0d want 1", rels); end
    nChecks++;
    if (relEdge - firstEdge + 1 != DEB + 3) begin
      nErrors++; $display("[TB] FAIL release_latency got %0d want %0d", relEdge - firstEdge + 1, DEB + 3);
    end
    nChecks++;
    if (pulses != 0) begin nErrors++; $display("[TB] FAIL release_no_pulse got %0d want 0", pulses); end
    nChecks++;
    if (Stable_out !== 1'b0) begin nErrors++; $display("[TB] FAIL release_stable got %b want 0", Stable_out); end
  endtask

  task automatic test_bounce();
    int startEdge, pulseEdge, pulses, rels;
    logic lvl;
    startEdge = edgeNo + 1; pulseEdge = -1; pulses = 0; rels = 0;
    for (int i = 0; i < 26; i++) begin
      lvl = (i < 3) || (i >= 4 && i < 14);
      step(lvl, 1'b0);
      nChecks++;
      if ({Pulse_out, Release_out, Stable_out} !== {expP, expR, mStable}) begin
        nErrors++;
        $display("[TB] FAIL bounce_cycle edge=%0d got PRS=%b%b%b want %b%b%b", edgeNo,
                 Pulse_out, Release_out, Stable_out, expP, expR, mStable);
      end
      if (Pulse_out) begin pulses++; pulseEdge = edgeNo; end
      if (Release_out) rels++;
    end
    nChecks++;
    if (pulses != 1) begin nErrors++; $display("[TB] FAIL bounce_pulses got %0d want 1", pulses); end
    nChecks++;
    if (pulseEdge - (startEdge + 4) + 1 != DEB + 3) begin
      nErrors++; $display("[TB] FAIL bounce_latency got %0d want %0d", pulseEdge - (startEdge + 4) + 1, DEB + 3);
    end
    nChecks++;
    if (rels != 1) begin nErrors++; $display("[TB] FAIL bounce_releases got %0d want 1", rels); end
  endtask

  task automatic test_reset_mid_count();
    int firstEdge, pulseEdge;
    pulseEdge = -1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    nChecks++;
    if ({Pulse_out, Release_out, Stable_out} !== 3'b000) begin
      nErrors++; $display("[TB] FAIL midreset_outputs got PRS=%b%b%b want 000", Pulse_out, Release_out, Stable_out);
    end
    firstEdge = edgeNo + 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      nChecks++;
      if ({Pulse_out, Release_out, Stable_out} !== {expP, expR, mStable}) begin
        nErrors++;
        $display("[TB] FAIL midreset_cycle edge=%0d got PRS=%b%b%b want %b%b%b", edgeNo,
                 Pulse_out, Release_out, Stable_out, expP, expR, mStable);
      end
      if (Pulse_out && pulseEdge < 0) pulseEdge = edgeNo;
    end
    nChecks++;
    if (pulseEdge - firstEdge + 1 != DEB + 3) begin
      nErrors++; $display("[TB] FAIL midreset_latency got %0d want %0d", pulseEdge - firstEdge + 1, DEB + 3);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_hold_long();
    int accEdge, relOff, rels;
    int offs[$];
    int want[$];
`ifdef AUTO_REPEAT_EN
    want = '{0, RD, RD + RP, RD + 2 * RP, RD + 3 * RP};
`else
    want = '{0};
`endif
    accEdge = -1; relOff = -1; rels = 0;
    for (int i = 0; i < 20 && accEdge < 0; i++) begin
      step(1'b1, 1'b0);
      if (Pulse_out) accEdge = edgeNo;
    end
    nChecks++;
    if (accEdge < 0) begin
      nErrors++; $display("[TB] FAIL hold_accept got no pulse want pulse within 20 edges");
    end else begin
      offs.push_back(0);
      for (int i = 0; i < 50; i++) begin
        step(i < 30, 1'b0);
        nChecks++;
        if ({Pulse_out, Release_out, Stable_out} !== {expP, expR, mStable}) begin
          nErrors++;
          $display("[TB] FAIL hold_cycle edge=%0d got PRS=%b%b%b want %b%b%b", edgeNo,
                   Pulse_out, Release_out, Stable_out, expP, expR, mStable);
        end
        if (Pulse_out) offs.push_back(edgeNo - accEdge);
        if (Release_out) begin rels++; relOff = edgeNo - accEdge; end
      end
      nChecks++;
      if (offs.size() != want.size()) begin
        nErrors++; $display("[TB] FAIL hold_pulse_count got %0d want %0d", offs.size(), want.size());
      end else begin
        for (int k = 0; k < want.size(); k++) begin
          nChecks++;
          if (offs[k] != want[k]) begin
            nErrors++; $display("[TB] FAIL hold_pulse_offset[%0d] got %0d want %0d", k, offs[k], want[k]);
          end
        end
      end
      nChecks++;
      if (rels != 1 || relOff != 30 + DEB + 3) begin
        nErrors++; $display("[TB] FAIL hold_release got count=%0d off=%0d want 1 off=%0d", rels, relOff, 30 + DEB + 3);
      end
    end
  endtask

  task automatic test_random();
    logic lvl;
    int runLen;
    lvl = 1'b0; runLen = 0;
    for (int i = 0; i < 600; i++) begin
      if (runLen == 0) begin
        lvl = 1'($urandom_range(0, 1));
        runLen = $urandom_range(1, 9);
      end
      runLen--;
      step(lvl, $urandom_range(0, 79) == 0);
      nChecks++;
      if ({Pulse_out, Release_out, Stable_out} !== {expP, expR, mStable}) begin
        nErrors++;
        $display("[TB] FAIL random_cycle edge=%0d got PRS=%b%b%b want %b%b%b", edgeNo,
                 Pulse_out, Release_out, Stable_out, expP, expR, mStable);
      end
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_toggle();
    logic want[3];
    want = '{1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      nChecks++;
      if (toggleQ !== want[p]) begin
        nErrors++; $display("[TB] FAIL toggle_after_press%0d got %b want %b", p, toggleQ, want[p]);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_reset_mid_count();
    test_hold_long();
    test_random();
    test_toggle();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
